ghr_ckpt_ctrl: RTL

Checkpoint/recovery controller for the speculative global history register (GHR) of the branch predictor. It sequences the GHR shift register. It shifts in each accepted prediction and records a checkpoint of the pre-update history in an in-order FIFO. On an in-order branch resolution that reveals a mispredict, it squashes all younger checkpoints and restores the corrected history through the register's reload port.

---
 rtl/ghr_ckpt_if.sv | 32 +++
 rtl/ghr_ckpt_ctrl.sv | 83 ++++++++
 2 files changed

// File: rtl/ghr_ckpt_if.sv
// ghr_ckpt_if: prediction/resolution handshakes, GHR control and status bundle for ghr_ckpt_ctrl
interface ghr_ckpt_if #(
    parameter int HIST_W = 14,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
);
    localparam int PW = $clog2(DEPTH) + 1;
    logic              pred_valid;
    logic              pred_taken;
    logic              pred_ready;
    logic              res_valid;
    logic              res_taken;
    logic              res_ready;
    logic [HIST_W-1:0] ghr_rd_data;
    logic              ghr_wr_en;
    logic              ghr_wr_data;
    logic              ghr_re_en;
    logic [HIST_W-1:0] ghr_re_data;
    logic [PW-1:0]     inflight;
    logic [CNT_W-1:0]  br_cnt;
    logic [CNT_W-1:0]  mispred_cnt;
    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken, ghr_rd_data,
        output pred_ready, res_ready, ghr_wr_en, ghr_wr_data, ghr_re_en, ghr_re_data,
               inflight, br_cnt, mispred_cnt
    );
    modport master (
        output pred_valid, pred_taken, res_valid, res_taken, ghr_rd_data,
        input  pred_ready, res_ready, ghr_wr_en, ghr_wr_data, ghr_re_en, ghr_re_data,
               inflight, br_cnt, mispred_cnt
    );
endinterface

// File: rtl/ghr_ckpt_ctrl.sv
// ghr_ckpt_ctrl: speculative GHR checkpoint FIFO with in-order mispredict recovery
module ghr_ckpt_ctrl #(
    parameter int HIST_W = 14,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input logic     clk,
    input logic     reset,
    ghr_ckpt_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] RECOVER = 1'b1;

    logic [0:0]        r_state;
    logic [AW:0]       r_wp;
    logic [AW:0]       r_rp;
    logic [HIST_W:0]   r_fifo [DEPTH];
    logic [HIST_W-1:0] r_rec_hist;
    logic [CNT_W-1:0]  r_br_cnt;
    logic [CNT_W-1:0]  r_mis_cnt;
    logic [HIST_W:0]   w_head;
    logic              w_run;
    logic              w_full;
    logic              w_empty;
    logic              w_pf;
    logic              w_rf;
    logic              w_mis;
    logic              w_push;
    logic              w_pop;

    // handshakes gated off during reset; a mispredict squashes any same-cycle push
    always_comb begin
        w_run   = r_state == RUN;
        w_empty = r_wp == r_rp;
        w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
        w_head  = r_fifo[r_rp[AW-1:0]];
        w_pf    = bus.pred_valid && w_run && !w_full && !reset;
        w_rf    = bus.res_valid && w_run && !w_empty && !reset;
        w_mis   = w_rf && (bus.res_taken != w_head[0]);
        w_push  = w_pf && !w_mis;
        w_pop   = w_rf && !w_mis;
    end

    assign bus.pred_ready  = w_run && !w_full;
    assign bus.res_ready   = w_run && !w_empty;
    assign bus.ghr_wr_en   = w_push;
    assign bus.ghr_wr_data = bus.pred_taken;
    assign bus.ghr_re_en   = r_state == RECOVER;
    assign bus.ghr_re_data = r_rec_hist;
    assign bus.inflight    = r_wp - r_rp;
    assign bus.br_cnt      = r_br_cnt;
    assign bus.mispred_cnt = r_mis_cnt;

    // checkpoint storage holds {pre-update history, predicted direction}
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wp[AW-1:0]] <= {bus.ghr_rd_data, bus.pred_taken};
    end

    // pointers, recovery FSM, corrected history and saturating statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wp       <= '0;
            r_rp       <= '0;
            r_rec_hist <= '0;
            r_br_cnt   <= '0;
            r_mis_cnt  <= '0;
        end else begin
            r_state <= w_mis ? RECOVER : RUN;
            if (w_mis) begin
                r_wp       <= '0;
                r_rp       <= '0;
                r_rec_hist <= {w_head[HIST_W-1:1], bus.res_taken};
            end else begin
                if (w_push) r_wp <= r_wp + 1'b1;
                if (w_pop) r_rp <= r_rp + 1'b1;
            end
            if (w_rf && !(&r_br_cnt)) r_br_cnt <= r_br_cnt + 1'b1;
            if (w_mis && !(&r_mis_cnt)) r_mis_cnt <= r_mis_cnt + 1'b1;
        end
    end
endmodule
